ccff_chain_loader: RTL and testbench
====================================

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter DATA_W, default 8, configuration word width in bits; legal range 2..32.
REQ-002 Parameter LEN_W, default 16, width of the chain-length field.
REQ-003 prog_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 prog_reset  input  1  reset, synchronous and active-high.
REQ-005 cfg_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 cfg_len  input  LEN_W  total chain length in bits; sampled with cfg_start.
REQ-007 cfg_word_data  input  DATA_W  bitstream word; shifted out MSB first.
REQ-008 cfg_word_valid  input  1  cfg_word_data is valid.
REQ-009 cfg_word_ready  output  1  loader accepts a word on this cycle.
REQ-010 ccff_head  output  1  serial bit to the configuration-chain head of the downstream I/O grid tiles.
REQ-011 ccff_shift_en  output  1  chain clock enable; the chain samples ccff_head only on edges where this is 1.
REQ-012 ccff_tail  input  1  serial bit returning from the chain tail.
REQ-013 isol_n  output  1  fabric I/O isolation to the grid tiles; 0 = isolated.
REQ-014 rb_data  output  DATA_W  readback word deserialized from ccff_tail.
REQ-015 rb_valid  output  1  one-cycle strobe; rb_data is valid.
REQ-016 cfg_busy  output  1  load in progress.
REQ-017 cfg_done  output  1  one-cycle pulse when a load completes.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, SHIFT and DONE.
REQ-019 IDLE: on cfg_start with cfg_len!=0, the FSM SHALL latch cfg_len into remaining, drive isol_n=0, and go to FETCH.
REQ-020 IDLE: on cfg_start with cfg_len==0, the FSM SHALL go directly to DONE with zero shifts; isol_n SHALL be forced to 0 for that one cycle.
REQ-021 FETCH: cfg_word_ready SHALL be 1 and ccff_shift_en SHALL be 0.
- On cfg_word_valid, load the word into the shift register, set bit_cnt=DATA_W, and go to SHIFT.
REQ-022 SHIFT, each cycle:
- ccff_shift_en=1 and ccff_head = shift register MSB.
- Shift the register left by one.
- Decrement remaining and bit_cnt.
- cfg_word_ready=0.
REQ-023 SHIFT exit: when remaining reaches 0 the FSM SHALL go to DONE, even mid-word; any unshifted bits of the final word are discarded. Otherwise, when bit_cnt reaches 0, it SHALL go to FETCH.
REQ-024 Throughput: each full word SHALL take exactly DATA_W SHIFT cycles plus at least 1 FETCH cycle. There is no back-to-back word acceptance.
REQ-025 Outside SHIFT, ccff_shift_en and ccff_head SHALL both be 0.
REQ-026 Readback: on every cycle with ccff_shift_en=1, ccff_tail SHALL be shifted into the LSB of a readback register.
- After every DATA_W captured bits, rb_data SHALL update and rb_valid SHALL pulse on the following cycle.
- A partial final readback word SHALL be zero-padded at the LSBs and emitted on entry to DONE.
REQ-027 DONE: the FSM SHALL pulse cfg_done for one cycle, set isol_n=1, and return to IDLE.
REQ-028 cfg_busy SHALL be 1 in FETCH, SHIFT and DONE, and 0 in IDLE.
REQ-029 cfg_start SHALL be ignored while cfg_busy=1.
REQ-030 A new cfg_start after a completed load SHALL drive isol_n back to 0 on the next cycle.
REQ-031 cfg_word_valid outside FETCH SHALL be ignored; the word is not consumed.
REQ-032 remaining SHALL be LEN_W bits wide and SHALL never wrap below 0.

Reset
REQ-033 On prog_reset, in any state including mid-shift, the block SHALL enter IDLE and drive outputs to:
- isol_n=0, ccff_head=0, ccff_shift_en=0, cfg_word_ready=0
- cfg_busy=0, cfg_done=0, rb_valid=0, rb_data=0
- shift register, bit_cnt, remaining and readback register all cleared.
REQ-034 After reset, isol_n SHALL stay 0 until the first cfg_done.

Verification
REQ-035 Reset mid-load: assert prog_reset during SHIFT of len=16 -> next cycle IDLE, ccff_shift_en=0, isol_n=0, cfg_busy=0; no cfg_done.
REQ-036 Full-word load: len=16, words 0xA5 then 0x3C, valid held high -> ccff_head sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 shift-enabled cycles; exactly 2 FETCH cycles; cfg_done at cycle 19 after start; isol_n=1 thereafter.
REQ-037 Partial last word: len=12, words 0xFF, 0xF0 -> 12 shift-enabled cycles with head=1, then DONE; the low nibble of 0xF0 is never driven; cfg_word_ready never rises a third time.
REQ-038 Zero length: cfg_len=0 with cfg_start -> cfg_done the next cycle, ccff_shift_en never 1.
REQ-039 Readback loop: tie ccff_tail to a 4-bit delay model of the chain; len=12, words 0x96, 0x50 -> rb_data 0x09 after 8 bits, then 0x60 (zero-padded) in DONE; rb_valid pulses exactly twice.
REQ-040 Protocol stall and ignore: hold valid low for 5 FETCH cycles and assert cfg_start mid-load -> ccff_shift_en stays 0 while stalled, the second start is ignored, and the load completes unchanged.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Serial configuration-chain loader: fetches DATA_W-bit words, shifts cfg_len bits MSB-first
// into the downstream CCFF chain, and deserializes the returning tail bits for readback.
`timescale 1ns/1ps
module ccff_chain_loader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] cfg_word_data,
  input  logic              cfg_word_valid,
  output logic              cfg_word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              isol_q, isol_d;
  logic [DATA_W-1:0] rb_sr_q, rb_sr_d;
  logic [CW-1:0]     rb_cnt_q, rb_cnt_d;
  logic [DATA_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  logic [DATA_W-1:0] rb_word;
  logic [CW-1:0]     rb_cnt_inc;

  assign rb_word    = {rb_sr_q[DATA_W-2:0], ccff_tail};
  assign rb_cnt_inc = rb_cnt_q + CW'(1);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      rem_q      <= '0;
      isol_q     <= 1'b0;
      rb_sr_q    <= '0;
      rb_cnt_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rem_q      <= rem_d;
      isol_q     <= isol_d;
      rb_sr_q    <= rb_sr_d;
      rb_cnt_q   <= rb_cnt_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    rem_d      = rem_q;
    isol_d     = isol_q;
    rb_sr_d    = rb_sr_q;
    rb_cnt_d   = rb_cnt_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          isol_d   = 1'b0;
          rb_sr_d  = '0;
          rb_cnt_d = '0;
          if (cfg_len != '0) begin
            rem_d   = cfg_len;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      FETCH: begin
        if (cfg_word_valid) begin
          sr_d      = cfg_word_data;
          bit_cnt_d = CW'(DATA_W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        sr_d      = {sr_q[DATA_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q - CW'(1);
        if (rem_q != '0) rem_d = rem_q - LEN_W'(1);
        if (rb_cnt_inc == CW'(DATA_W)) begin
          rb_data_d  = rb_word;
          rb_valid_d = 1'b1;
          rb_sr_d    = '0;
          rb_cnt_d   = '0;
        end else begin
          rb_sr_d  = rb_word;
          rb_cnt_d = rb_cnt_inc;
        end
        if (rem_q <= LEN_W'(1)) begin
          state_d = DONE;
          // Flush a partial readback word, left-aligned so unused LSBs read as zero
          if (rb_cnt_inc != CW'(DATA_W)) begin
            rb_data_d  = rb_word << (CW'(DATA_W) - rb_cnt_inc);
            rb_valid_d = 1'b1;
            rb_sr_d    = '0;
            rb_cnt_d   = '0;
          end
        end else if (bit_cnt_q == CW'(1)) begin
          state_d = FETCH;
        end
      end
      DONE: begin
        isol_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_word_ready = (state_q == FETCH);
  assign ccff_shift_en  = (state_q == SHIFT);
  assign ccff_head      = (state_q == SHIFT) & sr_q[DATA_W-1];
  assign cfg_busy       = (state_q != IDLE);
  assign cfg_done       = (state_q == DONE);
  assign isol_n         = isol_q;
  assign rb_data        = rb_data_q;
  assign rb_valid       = rb_valid_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench for ccff_chain_loader: directed scenarios plus randomized loads
// checked against a bitstream-level model of the chain and a 4-deep chain delay.
`timescale 1ns/1ps
module tb_ccff_chain_loader;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 16;

  logic              prog_clk = 1'b0;
  logic              prog_reset;
  logic              cfg_start;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] cfg_word_data;
  logic              cfg_word_valid;
  logic              cfg_word_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail;
  logic              isol_n;
  logic [DATA_W-1:0] rb_data;
  logic              rb_valid;
  logic              cfg_busy;
  logic              cfg_done;

  ccff_chain_loader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_word_data(cfg_word_data), .cfg_word_valid(cfg_word_valid),
    .cfg_word_ready(cfg_word_ready), .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en),
    .ccff_tail(ccff_tail), .isol_n(isol_n), .rb_data(rb_data), .rb_valid(rb_valid),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream chain modelled as a 4-bit delay line clocked by ccff_shift_en
  logic       chain_clr;
  logic [3:0] chain;
  always @(posedge prog_clk) begin
    if (chain_clr) chain <= 4'b0;
    else if (ccff_shift_en) chain <= {chain[2:0], ccff_head};
  end
  assign ccff_tail = chain[3];

  int checks = 0;
  int errors = 0;

  logic [7:0]  words [16];
  logic [63:0] got_heads, exp_heads_v;
  logic [7:0]  rbs [8];
  logic [7:0]  exp_rbs [8];
  int rb_n, exp_rb_n, exp_words;
  int n_shift, n_fetch, n_rises, n_done, n_acc, done_cyc, shift_before_word;
  logic isol_done, isol_after, busy_after;

  // Expected chain contents and readback, derived from the bitstream alone
  function automatic void compute_model(input int len);
    logic [7:0] acc;
    int cnt;
    logic b;
    exp_heads_v = '0; exp_rb_n = 0; acc = '0; cnt = 0;
    for (int i = 0; i < len; i++) exp_heads_v = {exp_heads_v[62:0], words[i/8][7-(i%8)]};
    for (int j = 0; j < len; j++) begin
      b = (j < 4) ? 1'b0 : words[(j-4)/8][7-((j-4)%8)];
      acc = {acc[6:0], b};
      cnt++;
      if (cnt == 8) begin exp_rbs[exp_rb_n] = acc; exp_rb_n++; acc = '0; cnt = 0; end
    end
    if (cnt != 0) begin exp_rbs[exp_rb_n] = acc << (8 - cnt); exp_rb_n++; end
    exp_words = (len + 7) / 8;
  endfunction

  // Drives one load (start in cycle 0) and records what the DUT does, cycle by cycle
  task automatic run_load(input int len, input int nw, input int stall, input bit restart);
    int idx, stall_left, done_at;
    logic prev_rdy;
    idx = 0; stall_left = stall; done_at = -1; prev_rdy = 1'b0;
    got_heads = '0; n_shift = 0; rb_n = 0; n_fetch = 0; n_rises = 0; n_done = 0;
    shift_before_word = 0; isol_done = 1'b1; isol_after = 1'b0; busy_after = 1'b1;
    chain_clr = 1'b1; cfg_start = 1'b1; cfg_len = LEN_W'(len);
    @(posedge prog_clk); #1;
    chain_clr = 1'b0; cfg_start = 1'b0;
    for (int cyc = 1; cyc < 3000; cyc++) begin
      cfg_word_valid = (idx < nw) && (stall_left == 0);
      cfg_word_data  = words[idx % 16];
      cfg_start      = restart && (cyc == 6);
      cfg_len        = (restart && cyc == 6) ? LEN_W'(3) : LEN_W'(len);
      @(negedge prog_clk);
      if (cfg_word_ready) begin n_fetch++; if (!prev_rdy) n_rises++; end
      prev_rdy = cfg_word_ready;
      if (ccff_shift_en) begin
        got_heads = {got_heads[62:0], ccff_head};
        n_shift++;
        if (idx == 0) shift_before_word++;
      end
      if (cfg_word_ready && !cfg_word_valid && stall_left > 0) stall_left--;
      if (cfg_word_ready && cfg_word_valid) idx++;
      if (rb_valid && rb_n < 8) begin rbs[rb_n] = rb_data; rb_n++; end
      if (cfg_done) begin
        n_done++;
        if (done_at < 0) begin done_at = cyc; isol_done = isol_n; end
      end
      if (done_at >= 0 && cyc == done_at + 1) begin isol_after = isol_n; busy_after = cfg_busy; end
      @(posedge prog_clk); #1;
      if (done_at >= 0 && cyc >= done_at + 2) break;
    end
    cfg_start = 1'b0; cfg_word_valid = 1'b0;
    n_acc = idx; done_cyc = done_at;
  endtask

  task automatic test_reset;
    prog_reset = 1'b1; chain_clr = 1'b1;
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    checks++;
    if ({isol_n, ccff_head, ccff_shift_en, cfg_word_ready, cfg_busy, cfg_done, rb_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got isol=%b head=%b sh=%b rdy=%b busy=%b done=%b rbv=%b, want all 0",
               isol_n, ccff_head, ccff_shift_en, cfg_word_ready, cfg_busy, cfg_done, rb_valid);
    end
    checks++;
    if (rb_data !== 8'h00) begin errors++; $display("FAIL reset_rb_data: got %h want 00", rb_data); end
    @(posedge prog_clk); #1;
    prog_reset = 1'b0; chain_clr = 1'b0;
  endtask

  task automatic test_reset_mid_load;
    int waited, dones;
    words[0] = 8'hA5; words[1] = 8'h3C;
    chain_clr = 1'b1; cfg_start = 1'b1; cfg_len = 16'd16;
    cfg_word_valid = 1'b1; cfg_word_data = words[0];
    @(posedge prog_clk); #1;
    cfg_start = 1'b0; chain_clr = 1'b0;
    waited = 0;
    do begin @(negedge prog_clk); waited++; end while (!ccff_shift_en && waited < 20);
    checks++;
    if (!ccff_shift_en) begin errors++; $display("FAIL midload_reach_shift: shift_en=%b want 1", ccff_shift_en); end
    @(posedge prog_clk); #1;
    prog_reset = 1'b1;
    @(posedge prog_clk); #1;
    prog_reset = 1'b0; cfg_word_valid = 1'b0;
    @(negedge prog_clk);
    checks++;
    if ({ccff_shift_en, isol_n, cfg_busy, cfg_word_ready} !== 4'b0) begin
      errors++;
      $display("FAIL midload_reset_state: got sh=%b isol=%b busy=%b rdy=%b want 0000",
               ccff_shift_en, isol_n, cfg_busy, cfg_word_ready);
    end
    dones = 0;
    repeat (6) begin @(negedge prog_clk); if (cfg_done || cfg_busy) dones++; end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL midload_no_done: got %0d done/busy cycles want 0", dones); end
  endtask

  task automatic test_full_word;
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h77;
    compute_model(16);
    run_load(16, 3, 0, 1'b0);
    checks++;
    if (got_heads[15:0] !== 16'hA53C || got_heads[15:0] !== exp_heads_v[15:0]) begin
      errors++; $display("FAIL full_heads: got %h want %h", got_heads[15:0], exp_heads_v[15:0]);
    end
    checks++;
    if (n_shift != 16) begin errors++; $display("FAIL full_shift_cnt: got %0d want 16", n_shift); end
    checks++;
    if (n_fetch != 2) begin errors++; $display("FAIL full_fetch_cycles: got %0d want 2", n_fetch); end
    checks++;
    if (done_cyc != 19 || n_done != 1) begin
      errors++; $display("FAIL full_done_cycle: got cyc %0d cnt %0d want 19/1", done_cyc, n_done);
    end
    checks++;
    if (isol_done !== 1'b0 || isol_after !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL full_isol: got done-cycle isol %b after %b busy %b want 0 1 0", isol_done, isol_after, busy_after);
    end
    checks++;
    if (n_acc != 2) begin errors++; $display("FAIL full_words_taken: got %0d want 2", n_acc); end
  endtask

  task automatic test_partial;
    words[0] = 8'hFF; words[1] = 8'hF0; words[2] = 8'hAA;
    compute_model(12);
    run_load(12, 3, 0, 1'b0);
    checks++;
    if (got_heads[11:0] !== 12'hFFF || n_shift != 12) begin
      errors++; $display("FAIL partial_heads: got %h/%0d want fff/12", got_heads[11:0], n_shift);
    end
    checks++;
    if (n_rises != 2 || n_acc != 2) begin
      errors++; $display("FAIL partial_ready_rises: got %0d rises %0d words want 2/2", n_rises, n_acc);
    end
    checks++;
    if (done_cyc != 1 + 2 + 12) begin errors++; $display("FAIL partial_done_cycle: got %0d want 15", done_cyc); end
  endtask

  task automatic test_zero_len;
    run_load(0, 2, 0, 1'b0);
    checks++;
    if (done_cyc != 1 || n_shift != 0 || n_fetch != 0) begin
      errors++;
      $display("FAIL zero_len: got done %0d shifts %0d fetch %0d want 1/0/0", done_cyc, n_shift, n_fetch);
    end
    checks++;
    if (isol_done !== 1'b0 || isol_after !== 1'b1) begin
      errors++; $display("FAIL zero_isol: got %b then %b want 0 then 1", isol_done, isol_after);
    end
    checks++;
    if (rb_n != 0) begin errors++; $display("FAIL zero_rb: got %0d strobes want 0", rb_n); end
  endtask

  task automatic test_readback;
    words[0] = 8'h96; words[1] = 8'h50;
    compute_model(12);
    run_load(12, 2, 0, 1'b0);
    checks++;
    if (rb_n != 2) begin errors++; $display("FAIL rb_count: got %0d want 2", rb_n); end
    checks++;
    if (rbs[0] !== 8'h09 || rbs[0] !== exp_rbs[0]) begin errors++; $display("FAIL rb_word0: got %h want 09", rbs[0]); end
    checks++;
    if (rbs[1] !== 8'h60 || rbs[1] !== exp_rbs[1]) begin errors++; $display("FAIL rb_word1: got %h want 60", rbs[1]); end
  endtask

  task automatic test_stall_ignore;
    words[0] = 8'hC3; words[1] = 8'h5A; words[2] = 8'h11;
    compute_model(16);
    run_load(16, 3, 5, 1'b1);
    checks++;
    if (shift_before_word != 0) begin errors++; $display("FAIL stall_shift: got %0d shifts while stalled want 0", shift_before_word); end
    checks++;
    if (got_heads[15:0] !== exp_heads_v[15:0] || n_shift != 16) begin
      errors++; $display("FAIL stall_heads: got %h/%0d want %h/16", got_heads[15:0], n_shift, exp_heads_v[15:0]);
    end
    checks++;
    if (done_cyc != 1 + 5 + 2 + 16 || n_done != 1) begin
      errors++; $display("FAIL stall_done: got cyc %0d cnt %0d want 24/1", done_cyc, n_done);
    end
    checks++;
    if (n_fetch != 7) begin errors++; $display("FAIL stall_fetch: got %0d want 7", n_fetch); end
  endtask

  task automatic test_random;
    int len, stall, nw;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 40);
      stall = $urandom_range(0, 3);
      for (int w = 0; w < 16; w++) words[w] = 8'($urandom);
      compute_model(len);
      nw = exp_words + 1;
      run_load(len, nw, stall, 1'b0);
      checks++;
      if (got_heads !== exp_heads_v || n_shift != len) begin
        errors++; $display("FAIL rand_heads[%0d]: got %h/%0d want %h/%0d", it, got_heads, n_shift, exp_heads_v, len);
      end
      checks++;
      if (n_acc != exp_words || done_cyc != 1 + stall + exp_words + len) begin
        errors++;
        $display("FAIL rand_timing[%0d]: got words %0d done %0d want %0d/%0d", it, n_acc, done_cyc,
                 exp_words, 1 + stall + exp_words + len);
      end
      checks++;
      if (rb_n != exp_rb_n) begin errors++; $display("FAIL rand_rb_count[%0d]: got %0d want %0d", it, rb_n, exp_rb_n); end
      for (int k = 0; k < exp_rb_n && k < rb_n; k++) begin
        checks++;
        if (rbs[k] !== exp_rbs[k]) begin
          errors++; $display("FAIL rand_rb_word[%0d.%0d]: got %h want %h", it, k, rbs[k], exp_rbs[k]);
        end
      end
      checks++;
      if (isol_after !== 1'b1) begin errors++; $display("FAIL rand_isol[%0d]: got %b want 1", it, isol_after); end
    end
  endtask

  initial begin
    prog_reset = 1'b1; chain_clr = 1'b1; cfg_start = 1'b0; cfg_len = '0;
    cfg_word_data = '0; cfg_word_valid = 1'b0;
    test_reset();
    test_reset_mid_load();
    test_full_word();
    test_partial();
    test_zero_len();
    test_readback();
    test_stall_ignore();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
